// File: rtl/snes_loader_pkg.sv
// snes_loader_pkg: shared state encoding and header constants for the SNES ROM loader
package snes_loader_pkg;
  typedef enum logic [2:0] {
    START,
    HDR0,
    HDR1,
    RD,
    WR_LO,
    WR_HI,
    DONE
  } state_t;
  localparam int HDR_WORDS = 2;
  localparam logic [7:0] MAGIC = 8'h53;
endpackage

// File: rtl/loader_flash_reader.sv
// loader_flash_reader: one-word-at-a-time valid/ready flash read with word capture and address stepping
module loader_flash_reader (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        set_addr,
  input  logic [23:0] base,
  input  logic        req,
  input  logic        flashmem_ready,
  input  logic [31:0] flash_dout,
  output logic        loading,
  output logic [23:0] flash_address,
  output logic [31:0] word,
  output logic        valid
);
  // hold the request until the flash answers, then capture, step the address and drop the request for a cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loading       <= 1'b0;
      flash_address <= '0;
      word          <= '0;
      valid         <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (set_addr) flash_address <= {base[23:2], 2'b00};
      if (loading && flashmem_ready) begin
        word          <= flash_dout;
        loading       <= 1'b0;
        flash_address <= flash_address + 24'd4;
        valid         <= 1'b1;
      end else if (req) begin
        loading <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/snes_rom_loader.sv
// snes_rom_loader: boot-time copy of one SNES game image from SPI flash to SDRAM; SNES_ROM_LOADER_MAGIC_EN enables the header magic check
module snes_rom_loader
  import snes_loader_pkg::*;
#(
  parameter logic [23:0] FLASH_BASE    = 24'h200000,
  parameter int          SLOT_SHIFT    = 21,
  parameter int          WR_GAP        = 8,
  parameter logic [23:0] ROM_MAX_BYTES = 24'h800000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  sel,
  output logic        loading,
  input  logic        flashmem_ready,
  output logic [23:0] flash_address,
  input  logic [31:0] flash_dout,
  output logic        wren,
  output logic [24:0] load_address,
  output logic [15:0] load_data,
  output logic        ready,
  output logic [7:0]  rom_type,
  output logic [23:0] rom_mask,
  output logic [23:0] ram_mask
);
  state_t      state;
  logic [23:0] slot;
  logic [23:0] slot_sel;
  logic [23:0] rom_size;
  logic [23:0] hdr_size;
  logic [23:0] end_addr;
  logic [7:0]  gap;
  logic        rd_req;
  logic        rd_valid;
  logic [31:0] rd_word;

  assign slot_sel = FLASH_BASE + (24'(sel) << SLOT_SHIFT);
  assign hdr_size = (rd_word[23:0] > ROM_MAX_BYTES) ? ROM_MAX_BYTES : rd_word[23:0];
  assign rd_req   = (state == HDR0 || state == HDR1 || state == RD) && !rd_valid;

  loader_flash_reader u_reader (
    .clk           (clk),
    .reset_n       (reset_n),
    .set_addr      (state == START),
    .base          (slot_sel),
    .req           (rd_req),
    .flashmem_ready(flashmem_ready),
    .flash_dout    (flash_dout),
    .loading       (loading),
    .flash_address (flash_address),
    .word          (rd_word),
    .valid         (rd_valid)
  );

  // header parse, payload write sequencing with a fixed write spacing, and completion flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= START;
      slot         <= '0;
      rom_size     <= '0;
      end_addr     <= '0;
      gap          <= '0;
      wren         <= 1'b0;
      load_address <= '0;
      load_data    <= '0;
      ready        <= 1'b0;
      rom_type     <= '0;
      rom_mask     <= '0;
      ram_mask     <= '0;
    end else begin
      wren <= 1'b0;
      if (gap != 8'd0) gap <= gap - 8'd1;
      if (wren) load_address <= load_address + 25'd2;
      case (state)
        START: begin
          slot  <= slot_sel;
          state <= HDR0;
        end
        HDR0: if (rd_valid) begin
          rom_type <= rd_word[31:24];
          rom_size <= hdr_size;
          rom_mask <= (hdr_size == 24'd0) ? 24'd0 : hdr_size - 24'd1;
          state    <= HDR1;
        end
        HDR1: if (rd_valid) begin
          ram_mask <= (rd_word[23:0] == 24'd0) ? 24'd0 : rd_word[23:0] - 24'd1;
          end_addr <= slot + 24'(HDR_WORDS * 4) + ((rom_size + 24'd3) & ~24'd3);
          state    <= (rom_size == 24'd0) ? DONE : RD;
`ifdef SNES_ROM_LOADER_MAGIC_EN
          if (rd_word[31:24] != MAGIC) begin
            rom_type <= '0;
            rom_mask <= '0;
            ram_mask <= '0;
            state    <= DONE;
          end
`endif
        end
        RD: if (rd_valid) state <= WR_LO;
        WR_LO: if (gap == 8'd0) begin
          wren      <= 1'b1;
          load_data <= rd_word[15:0];
          gap       <= 8'(WR_GAP - 1);
          state     <= WR_HI;
        end
        WR_HI: if (gap == 8'd0) begin
          wren      <= 1'b1;
          load_data <= rd_word[31:16];
          gap       <= 8'(WR_GAP - 1);
          state     <= (flash_address == end_addr) ? DONE : RD;
        end
        DONE: ready <= 1'b1;
        default: state <= START;
      endcase
    end
  end
endmodule

// File: tb/tb_snes_rom_loader.sv
// tb_snes_rom_loader: directed bench with a flash model, write scoreboard and spacing monitor; SNES_ROM_LOADER_MAGIC_EN selects the magic expectations
module tb_snes_rom_loader;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  sel = '0;
  logic        loading;
  logic        flashmem_ready = 1'b0;
  logic [23:0] flash_address;
  logic [31:0] flash_dout = '0;
  logic        wren;
  logic [24:0] load_address;
  logic [15:0] load_data;
  logic        ready;
  logic [7:0]  rom_type;
  logic [23:0] rom_mask;
  logic [23:0] ram_mask;

  int n_chk = 0;
  int n_fail = 0;
  logic [23:0] m_slot;
  logic [23:0] exp_faddr;
  logic [31:0] m_h0;
  logic [31:0] m_h1;
  int m_mode = 0;
  int max_lat = 0;
  int n_wr = 0;
  int cyc = 0;
  int last_wr = -1;
  int min_gap = 1000;

  always #5 clk = ~clk;

  snes_rom_loader dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sel           (sel),
    .loading       (loading),
    .flashmem_ready(flashmem_ready),
    .flash_address (flash_address),
    .flash_dout    (flash_dout),
    .wren          (wren),
    .load_address  (load_address),
    .load_data     (load_data),
    .ready         (ready),
    .rom_type      (rom_type),
    .rom_mask      (rom_mask),
    .ram_mask      (ram_mask)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pay_word(input int idx);
    if (m_mode == 0) return (idx == 0) ? 32'h44332211 : (idx == 1) ? 32'h88776655 : 32'h0;
    return {16'(idx) ^ 16'hA5C3, 16'(idx * 3 + 1)};
  endfunction

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    logic [23:0] off;
    off = a - m_slot;
    if (off == 24'd0) return m_h0;
    if (off == 24'd4) return m_h1;
    return pay_word(int'((off - 24'd8) >> 2));
  endfunction

  initial forever @(posedge clk) cyc++;

  // flash model: random answer latency, request hold/drop and address stepping checks
  initial begin
    int  lat;
    bit  pend;
    bit  resp;
    lat = 0;
    pend = 0;
    resp = 0;
    forever begin
      @(negedge clk);
      flashmem_ready = 1'b0;
      if (!reset_n) begin
        pend = 0;
        resp = 0;
      end else begin
        if (resp) check("load_drop", loading, 1'b0);
        resp = 0;
        if (pend) check("load_hold", loading, 1'b1);
        if (pend && !loading) pend = 0;
        if (loading) begin
          if (!pend) begin
            pend = 1;
            lat = int'($urandom_range(0, max_lat));
          end
          if (lat == 0) begin
            check("flash_addr", flash_address, exp_faddr);
            flashmem_ready = 1'b1;
            flash_dout = flash_word(flash_address);
            exp_faddr = exp_faddr + 24'd4;
            pend = 0;
            resp = 1;
          end else begin
            lat--;
          end
        end
      end
    end
  end

  // write scoreboard and spacing monitor
  initial forever begin
    logic [31:0] w;
    @(negedge clk);
    if (reset_n && wren) begin
      w = pay_word(n_wr / 2);
      check("wr_addr", 32'(load_address), 32'(2 * n_wr));
      check("wr_data", 32'(load_data), (n_wr % 2 == 1) ? 32'(w[31:16]) : 32'(w[15:0]));
      if (last_wr >= 0 && cyc - last_wr < min_gap) min_gap = cyc - last_wr;
      last_wr = cyc;
      n_wr++;
    end
  end

  task automatic do_reset(input logic [2:0] s, input logic [23:0] slot, input logic [31:0] h0,
                          input logic [31:0] h1, input int mode, input int lat);
    reset_n = 1'b0;
    sel = s;
    repeat (2) @(negedge clk);
    check("rst_loading", loading, 1'b0);
    check("rst_wren", wren, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_faddr", flash_address, 24'd0);
    check("rst_laddr", load_address, 25'd0);
    check("rst_ldata", load_data, 16'd0);
    check("rst_type", rom_type, 8'd0);
    check("rst_rmask", rom_mask, 24'd0);
    check("rst_amask", ram_mask, 24'd0);
    m_slot = slot;
    exp_faddr = slot;
    m_h0 = h0;
    m_h1 = h1;
    m_mode = mode;
    max_lat = lat;
    n_wr = 0;
    last_wr = -1;
    min_gap = 1000;
    reset_n = 1'b1;
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int i = 0; i < budget && n_wr < n; i++) @(posedge clk);
    check("wait_wr", n_wr, n);
  endtask

  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget && !ready; i++) @(negedge clk);
    check("wait_ready", ready, 1'b1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3'd0, 24'h200000, 32'h00080000, 32'h53000800, 0, 0);
    wait_writes(3, 300);
    check("t1_type", rom_type, 8'h00);
    check("t1_rmask", rom_mask, 24'h07FFFF);
    check("t1_amask", ram_mask, 24'h0007FF);
    check("t1_ready", ready, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (wren && n_wr == 99) break;
    end
    check("wr100_wren", wren, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_wren", wren, 1'b0);
    check("mid_ready", ready, 1'b0);
    check("mid_loading", loading, 1'b0);
    check("mid_laddr", load_address, 25'd0);
    check("mid_ldata", load_data, 16'd0);
    check("mid_rmask", rom_mask, 24'd0);
    check("mid_faddr", flash_address, 24'd0);
    do_reset(3'd0, 24'h200000, 32'h00080000, 32'h53000800, 0, 0);
    wait_writes(6, 400);

    do_reset(3'd3, 24'h800000, 32'h15000006, 32'h53002000, 1, 7);
    wait_ready(2000);
    repeat (40) @(negedge clk);
    check("t2_nwr", n_wr, 4);
    check("t2_type", rom_type, 8'h15);
    check("t2_rmask", rom_mask, 24'h000005);
    check("t2_amask", ram_mask, 24'h001FFF);
    check("t2_gap", min_gap, 8);
    check("t2_ready_hold", ready, 1'b1);
    check("t2_loading", loading, 1'b0);
    check("t2_faddr", flash_address, 24'h800010);

    do_reset(3'd1, 24'h400000, 32'h02000000, 32'h53000000, 1, 0);
    wait_ready(20);
    repeat (20) @(negedge clk);
    check("t3_nwr", n_wr, 0);
    check("t3_type", rom_type, 8'h02);
    check("t3_rmask", rom_mask, 24'h0);
    check("t3_amask", ram_mask, 24'h0);

    do_reset(3'd1, 24'h400000, 32'h01000040, 32'h53000100, 1, 3);
    wait_ready(3000);
    repeat (20) @(negedge clk);
    check("t4_nwr", n_wr, 32);
    check("t4_gap", min_gap, 8);
    check("t4_rmask", rom_mask, 24'h00003F);
    check("t4_amask", ram_mask, 24'h0000FF);
    check("t4_laddr", load_address, 25'd64);

    do_reset(3'd2, 24'h600000, 32'hFF900000, 32'h53000000, 1, 0);
    wait_writes(1, 300);
    check("t5_type", rom_type, 8'hFF);
    check("t5_rmask", rom_mask, 24'h7FFFFF);
    check("t5_amask", ram_mask, 24'h0);

    do_reset(3'd2, 24'h600000, 32'h21000008, 32'h00000800, 1, 0);
    wait_ready(500);
    repeat (20) @(negedge clk);
`ifdef SNES_ROM_LOADER_MAGIC_EN
    check("t6_nwr", n_wr, 0);
    check("t6_type", rom_type, 8'h00);
    check("t6_rmask", rom_mask, 24'h0);
    check("t6_amask", ram_mask, 24'h0);
`else
    check("t6_nwr", n_wr, 4);
    check("t6_type", rom_type, 8'h21);
    check("t6_rmask", rom_mask, 24'h000007);
    check("t6_amask", ram_mask, 24'h0007FF);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
